// File: rtl/rvsimple_mem_pkg.sv
// rtl/rvsimple_mem_pkg.sv - shared access-size types, FSM encodings and lane helpers for the data bridge
package rvsimple_mem_pkg;

    typedef enum logic [1:0] {
        MEM_B = 2'd0,
        MEM_H = 2'd1,
        MEM_W = 2'd2,
        MEM_D = 2'd3
    } mem_size_e;

    typedef logic [2:0] bridge_state_e;

    localparam bridge_state_e ST_IDLE  = 3'd0;
    localparam bridge_state_e ST_BEAT0 = 3'd1;
    localparam bridge_state_e ST_WAIT0 = 3'd2;
    localparam bridge_state_e ST_BEAT1 = 3'd3;
    localparam bridge_state_e ST_WAIT1 = 3'd4;
    localparam bridge_state_e ST_RESP  = 3'd5;
    localparam bridge_state_e ST_FAULT = 3'd6;

    function automatic int lane_off_w(input int xlen);
        return $clog2(xlen / 8);
    endfunction

    // Lane mask across two consecutive bus words; the upper half is the second beat.
    function automatic logic [15:0] byte_enable_mask(input logic [3:0] nbytes, input logic [2:0] off);
        return ((16'd1 << nbytes) - 16'd1) << off;
    endfunction

    function automatic logic lane_cross(input logic [3:0] nbytes, input logic [2:0] off, input int nb);
        return (int'(nbytes) + int'(off)) > nb;
    endfunction

endpackage

// File: rtl/data_lane_align.sv
// rtl/data_lane_align.sv - store lane shifting, byte enables and load merge/extension
module data_lane_align
    import rvsimple_mem_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]        off_i,
    input  logic [1:0]        size_i,
    input  logic              unsigned_i,
    input  logic [XLEN-1:0]   store_data_i,
    input  logic [XLEN-1:0]   beat0_data_i,
    input  logic [XLEN-1:0]   beat1_data_i,
    output logic [XLEN/8-1:0] be0_o,
    output logic [XLEN/8-1:0] be1_o,
    output logic [XLEN-1:0]   wdata0_o,
    output logic [XLEN-1:0]   wdata1_o,
    output logic [XLEN-1:0]   load_data_o
);
    localparam int NB = XLEN / 8;
    localparam int MW = 2 * NB;
    localparam int IW = $clog2(XLEN);

    logic [3:0]      nbytes;
    logic [MW-1:0]   mask;
    logic [XLEN-1:0] low;
    logic [XLEN-1:0] keep;
    logic [IW-1:0]   sidx;
    logic            sbit;
    int              nbits;

    assign nbytes   = 4'd1 << size_i;
    assign mask     = MW'(byte_enable_mask(nbytes, off_i));
    assign be0_o    = mask[NB-1:0];
    assign be1_o    = mask[MW-1:NB];
    assign wdata0_o = store_data_i << (8 * off_i);
    assign wdata1_o = store_data_i >> (8 * (NB - int'(off_i)));
    assign low      = XLEN'({beat1_data_i, beat0_data_i} >> (8 * off_i));

    always_comb begin
        nbits = 8 * int'(nbytes);
        if (nbits > XLEN) begin
            nbits = XLEN;
        end
        keep        = {XLEN{1'b1}} >> (XLEN - nbits);
        sidx        = IW'(nbits - 1);
        sbit        = ~unsigned_i & low[sidx];
        load_data_o = (low & keep) | ({XLEN{sbit}} & ~keep);
    end

endmodule

// File: rtl/data_memory_bridge.sv
// rtl/data_memory_bridge.sv - handshaked load/store unit splitting lane-crossing accesses into two bus beats
module data_memory_bridge
    import rvsimple_mem_pkg::*;
#(
    parameter int XLEN             = 32,
    parameter bit MISALIGNED_SPLIT = 1'b1
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [2:0]        data_format,
    input  logic [XLEN-1:0]   address,
    input  logic [XLEN-1:0]   write_data,
    output logic              resp_valid,
    output logic [XLEN-1:0]   read_data,
    output logic              fault,
    output logic              bus_req_valid,
    input  logic              bus_req_ready,
    output logic [XLEN-1:0]   bus_address,
    output logic              bus_write_enable,
    output logic [XLEN-1:0]   bus_write_data,
    output logic [XLEN/8-1:0] bus_byte_enable,
    input  logic              bus_resp_valid,
    input  logic [XLEN-1:0]   bus_read_data
);
    localparam int NB = XLEN / 8;
    localparam int OW = lane_off_w(XLEN);

    bridge_state_e   state_q, state_d;
    logic            write_q, write_d;
    logic [1:0]      size_q, size_d;
    logic            uns_q, uns_d;
    logic            cross_q, cross_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic [XLEN-1:0] beat0_q, beat0_d;
    logic [XLEN-1:0] rdata_q, rdata_d;

    logic [2:0]      off_in, off_q;
    logic [3:0]      nbytes_in;
    logic            size_bad, cross_in;
    logic [XLEN-1:0] align_q;
    logic [NB-1:0]   be0, be1;
    logic [XLEN-1:0] wdata0, wdata1, load_data, beat0_src;

    assign off_in    = 3'(address[OW-1:0]);
    assign nbytes_in = 4'd1 << data_format[1:0];
    assign size_bad  = (data_format[1:0] == MEM_D) && (XLEN != 64);
    assign cross_in  = lane_cross(nbytes_in, off_in, NB);
    assign off_q     = 3'(addr_q[OW-1:0]);
    assign align_q   = {addr_q[XLEN-1:OW], {OW{1'b0}}};
    // The second read beat completes the merge against the word captured from the first.
    assign beat0_src = (state_q == ST_WAIT1) ? beat0_q : bus_read_data;

    data_lane_align #(.XLEN(XLEN)) u_align (
        .off_i        (off_q),
        .size_i       (size_q),
        .unsigned_i   (uns_q),
        .store_data_i (wdata_q),
        .beat0_data_i (beat0_src),
        .beat1_data_i (bus_read_data),
        .be0_o        (be0),
        .be1_o        (be1),
        .wdata0_o     (wdata0),
        .wdata1_o     (wdata1),
        .load_data_o  (load_data)
    );

    assign req_ready        = (state_q == ST_IDLE);
    assign resp_valid       = (state_q == ST_RESP) || (state_q == ST_FAULT);
    assign fault            = (state_q == ST_FAULT);
    assign read_data        = rdata_q;
    assign bus_req_valid    = (state_q == ST_BEAT0) || (state_q == ST_BEAT1);
    assign bus_address      = (state_q == ST_BEAT1) ? align_q + XLEN'(NB) : align_q;
    assign bus_write_enable = bus_req_valid & write_q;
    assign bus_write_data   = (state_q == ST_BEAT1) ? wdata1 : wdata0;
    assign bus_byte_enable  = (state_q == ST_BEAT0) ? be0 :
                              (state_q == ST_BEAT1) ? be1 : '0;

    always_comb begin
        state_d = state_q;
        write_d = write_q;
        size_d  = size_q;
        uns_d   = uns_q;
        cross_d = cross_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        beat0_d = beat0_q;
        rdata_d = rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    write_d = req_write;
                    size_d  = data_format[1:0];
                    uns_d   = data_format[2];
                    cross_d = cross_in;
                    addr_d  = address;
                    wdata_d = write_data;
                    state_d = (size_bad || (cross_in && !MISALIGNED_SPLIT)) ? ST_FAULT : ST_BEAT0;
                end
            end
            ST_BEAT0: begin
                if (bus_req_ready) begin
                    state_d = write_q ? (cross_q ? ST_BEAT1 : ST_RESP) : ST_WAIT0;
                end
            end
            ST_WAIT0: begin
                if (bus_resp_valid) begin
                    if (cross_q) begin
                        beat0_d = bus_read_data;
                        state_d = ST_BEAT1;
                    end else begin
                        rdata_d = load_data;
                        state_d = ST_RESP;
                    end
                end
            end
            ST_BEAT1: begin
                if (bus_req_ready) begin
                    state_d = write_q ? ST_RESP : ST_WAIT1;
                end
            end
            ST_WAIT1: begin
                if (bus_resp_valid) begin
                    rdata_d = load_data;
                    state_d = ST_RESP;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            write_q <= 1'b0;
            size_q  <= 2'd0;
            uns_q   <= 1'b0;
            cross_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            beat0_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            write_q <= write_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            cross_q <= cross_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            beat0_q <= beat0_d;
            rdata_q <= rdata_d;
        end
    end

endmodule

// File: tb/tb_data_memory_bridge.sv
// tb/tb_data_memory_bridge.sv - directed bench for data_memory_bridge with split and no-split instances
module tb_data_memory_bridge;

    logic        clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset_n;
    logic        req_valid, req_valid2, req_write;
    logic [2:0]  data_format;
    logic [31:0] address, write_data;
    logic        req_ready, resp_valid, fault, bus_req_valid, bus_write_enable;
    logic [31:0] read_data, bus_address, bus_write_data;
    logic [3:0]  bus_byte_enable;
    logic        bus_req_ready, bus_resp_valid;
    logic [31:0] bus_read_data;

    logic        req_ready2, resp_valid2, fault2, bus_req_valid2, bus_write_enable2;
    logic [31:0] read_data2, bus_address2, bus_write_data2;
    logic [3:0]  bus_byte_enable2;
    logic        bus_req_ready2, bus_resp_valid2;
    logic [31:0] bus_read_data2;

    int n_checks = 0;
    int n_pass   = 0;

    data_memory_bridge #(.XLEN(32), .MISALIGNED_SPLIT(1'b1)) dut (
        .clock(clock), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .data_format(data_format), .address(address), .write_data(write_data),
        .resp_valid(resp_valid), .read_data(read_data), .fault(fault),
        .bus_req_valid(bus_req_valid), .bus_req_ready(bus_req_ready),
        .bus_address(bus_address), .bus_write_enable(bus_write_enable),
        .bus_write_data(bus_write_data), .bus_byte_enable(bus_byte_enable),
        .bus_resp_valid(bus_resp_valid), .bus_read_data(bus_read_data)
    );

    data_memory_bridge #(.XLEN(32), .MISALIGNED_SPLIT(1'b0)) dut_nosplit (
        .clock(clock), .reset_n(reset_n),
        .req_valid(req_valid2), .req_ready(req_ready2), .req_write(req_write),
        .data_format(data_format), .address(address), .write_data(write_data),
        .resp_valid(resp_valid2), .read_data(read_data2), .fault(fault2),
        .bus_req_valid(bus_req_valid2), .bus_req_ready(bus_req_ready2),
        .bus_address(bus_address2), .bus_write_enable(bus_write_enable2),
        .bus_write_data(bus_write_data2), .bus_byte_enable(bus_byte_enable2),
        .bus_resp_valid(bus_resp_valid2), .bus_read_data(bus_read_data2)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic load_seq(input string tag, input logic [2:0] fmt, input logic [31:0] addr,
                            input logic [31:0] a0, input logic [3:0] be0, input logic [31:0] d0,
                            input bit two, input logic [31:0] a1, input logic [3:0] be1,
                            input logic [31:0] d1, input logic [31:0] exp);
        @(negedge clock);
        check({tag, ".ready"}, req_ready, 1);
        req_valid = 1; req_write = 0; data_format = fmt; address = addr;
        @(negedge clock);
        req_valid = 0;
        check({tag, ".bv0"}, bus_req_valid, 1);
        check({tag, ".addr0"}, bus_address, a0);
        check({tag, ".be0"}, bus_byte_enable, be0);
        check({tag, ".we0"}, bus_write_enable, 0);
        @(negedge clock);
        check({tag, ".wait0"}, bus_req_valid, 0);
        bus_resp_valid = 1; bus_read_data = d0;
        @(negedge clock);
        bus_resp_valid = 0;
        if (two) begin
            check({tag, ".bv1"}, bus_req_valid, 1);
            check({tag, ".addr1"}, bus_address, a1);
            check({tag, ".be1"}, bus_byte_enable, be1);
            check({tag, ".early"}, resp_valid, 0);
            @(negedge clock);
            bus_resp_valid = 1; bus_read_data = d1;
            @(negedge clock);
            bus_resp_valid = 0;
        end
        check({tag, ".resp"}, resp_valid, 1);
        check({tag, ".fault"}, fault, 0);
        check({tag, ".rdata"}, read_data, exp);
        @(negedge clock);
        check({tag, ".pulse"}, resp_valid, 0);
        check({tag, ".hold"}, read_data, exp);
    endtask

    task automatic store_seq(input string tag, input logic [2:0] fmt, input logic [31:0] addr,
                             input logic [31:0] wd, input int hold,
                             input logic [31:0] a0, input logic [3:0] be0, input logic [31:0] w0,
                             input bit two, input logic [31:0] a1, input logic [3:0] be1,
                             input logic [31:0] w1);
        @(negedge clock);
        check({tag, ".ready"}, req_ready, 1);
        req_valid = 1; req_write = 1; data_format = fmt; address = addr; write_data = wd;
        bus_req_ready = (hold == 0);
        @(negedge clock);
        for (int i = 0; i <= hold; i++) begin
            // A competing request while busy must not disturb the beat.
            req_valid = (i < hold);
            address = ~addr;
            check({tag, ".bv0"}, bus_req_valid, 1);
            check({tag, ".addr0"}, bus_address, a0);
            check({tag, ".be0"}, bus_byte_enable, be0);
            check({tag, ".wd0"}, bus_write_data, w0);
            check({tag, ".we0"}, bus_write_enable, 1);
            if (i == hold) bus_req_ready = 1;
            @(negedge clock);
        end
        if (two) begin
            check({tag, ".bv1"}, bus_req_valid, 1);
            check({tag, ".addr1"}, bus_address, a1);
            check({tag, ".be1"}, bus_byte_enable, be1);
            check({tag, ".wd1"}, bus_write_data, w1);
            check({tag, ".early"}, resp_valid, 0);
            @(negedge clock);
        end
        check({tag, ".resp"}, resp_valid, 1);
        check({tag, ".fault"}, fault, 0);
        check({tag, ".idlebus"}, bus_req_valid, 0);
        @(negedge clock);
        check({tag, ".pulse"}, resp_valid, 0);
        req_write = 0;
    endtask

    task automatic fault_seq(input string tag, input bit which, input logic [2:0] fmt,
                             input logic [31:0] addr, input logic [31:0] prev_rd);
        @(negedge clock);
        req_write = 0; data_format = fmt; address = addr;
        if (which) req_valid2 = 1; else req_valid = 1;
        @(negedge clock);
        req_valid = 0; req_valid2 = 0;
        check({tag, ".resp"}, which ? resp_valid2 : resp_valid, 1);
        check({tag, ".fault"}, which ? fault2 : fault, 1);
        check({tag, ".nobus"}, which ? bus_req_valid2 : bus_req_valid, 0);
        check({tag, ".rdata"}, which ? read_data2 : read_data, prev_rd);
        @(negedge clock);
        check({tag, ".pulse"}, which ? resp_valid2 : resp_valid, 0);
        check({tag, ".ready"}, which ? req_ready2 : req_ready, 1);
        check({tag, ".nobus2"}, which ? bus_req_valid2 : bus_req_valid, 0);
    endtask

    initial begin
        reset_n = 0; req_valid = 0; req_valid2 = 0; req_write = 0; data_format = 0;
        address = 0; write_data = 0;
        bus_req_ready = 1; bus_resp_valid = 0; bus_read_data = 0;
        bus_req_ready2 = 1; bus_resp_valid2 = 0; bus_read_data2 = 0;
        repeat (3) @(negedge clock);
        check("rst.ready", req_ready, 1);
        check("rst.resp", resp_valid, 0);
        check("rst.fault", fault, 0);
        check("rst.bv", bus_req_valid, 0);
        check("rst.we", bus_write_enable, 0);
        check("rst.rdata", read_data, 0);
        check("rst.addr", bus_address, 0);
        check("rst.wdata", bus_write_data, 0);
        check("rst.be", bus_byte_enable, 0);
        reset_n = 1;

        load_seq("lw", 3'b010, 32'h100, 32'h100, 4'b1111, 32'hDEADBEEF, 0, 0, 0, 0, 32'hDEADBEEF);
        load_seq("lb", 3'b000, 32'h103, 32'h100, 4'b1000, 32'h80000000, 0, 0, 0, 0, 32'hFFFFFF80);
        load_seq("lbu", 3'b100, 32'h103, 32'h100, 4'b1000, 32'h80000000, 0, 0, 0, 0, 32'h00000080);
        load_seq("lh", 3'b001, 32'h102, 32'h100, 4'b1100, 32'h80010000, 0, 0, 0, 0, 32'hFFFF8001);
        load_seq("lhu", 3'b101, 32'h101, 32'h100, 4'b0110, 32'h00ABCD00, 0, 0, 0, 0, 32'h0000ABCD);
        load_seq("lw_split", 3'b010, 32'h102, 32'h100, 4'b1100, 32'h12345678,
                 1, 32'h104, 4'b0011, 32'h9ABCDEF0, 32'hDEF01234);
        load_seq("lh_split", 3'b001, 32'h103, 32'h100, 4'b1000, 32'hAB000000,
                 1, 32'h104, 4'b0001, 32'h000000CD, 32'hFFFFCDAB);
        fault_seq("fmt3", 0, 3'b011, 32'h100, 32'hFFFFCDAB);

        store_seq("sw_split", 3'b010, 32'h103, 32'h11223344, 3, 32'h100, 4'b1000, 32'h44000000,
                  1, 32'h104, 4'b0111, 32'h00112233);
        store_seq("sw", 3'b010, 32'h200, 32'hCAFEF00D, 0, 32'h200, 4'b1111, 32'hCAFEF00D, 0, 0, 0, 0);
        store_seq("sb", 3'b000, 32'h202, 32'h000000A5, 0, 32'h200, 4'b0100, 32'h00A50000, 0, 0, 0, 0);
        store_seq("sw_wrap", 3'b010, 32'hFFFFFFFE, 32'hAABBCCDD, 0, 32'hFFFFFFFC, 4'b1100, 32'hCCDD0000,
                  1, 32'h00000000, 4'b0011, 32'h0000AABB);

        fault_seq("ns_lh", 1, 3'b001, 32'h103, 32'h0);
        fault_seq("ns_fmt3", 1, 3'b011, 32'h100, 32'h0);
        @(negedge clock);
        req_write = 1; data_format = 3'b010; address = 32'h100; write_data = 32'h1; req_valid2 = 1;
        @(negedge clock);
        req_valid2 = 0;
        check("ns_sw.bv", bus_req_valid2, 1);
        check("ns_sw.be", bus_byte_enable2, 4'b1111);
        check("ns_sw.noresp", resp_valid2, 0);
        @(negedge clock);
        check("ns_sw.resp", resp_valid2, 1);
        check("ns_sw.fault", fault2, 0);
        req_write = 0;

        @(negedge clock);
        req_valid = 1; req_write = 0; data_format = 3'b010; address = 32'h300;
        @(negedge clock);
        req_valid = 0;
        check("rstw.beat", bus_req_valid, 1);
        @(negedge clock);
        check("rstw.wait", bus_req_valid, 0);
        reset_n = 0;
        @(negedge clock);
        reset_n = 1;
        check("rstw.ready", req_ready, 1);
        check("rstw.bv", bus_req_valid, 0);
        check("rstw.resp", resp_valid, 0);
        check("rstw.rdata", read_data, 0);
        bus_resp_valid = 1; bus_read_data = 32'h55555555;
        @(negedge clock);
        bus_resp_valid = 0;
        check("rstw.late", resp_valid, 0);
        check("rstw.ready2", req_ready, 1);
        @(negedge clock);
        check("rstw.late2", resp_valid, 0);
        check("rstw.rdata2", read_data, 0);

        load_seq("recover", 3'b100, 32'h103, 32'h100, 4'b1000, 32'h80000000, 0, 0, 0, 0, 32'h00000080);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
